// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I fetch constants and the fetch buffer entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of fetch entries (push/pop/flush; count, head, full, empty)
module fetch_buffer import riscv_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch front end feeding decode from a 1-cycle-latency imem via a small buffer
module fetch_unit import riscv_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int BUF_DEPTH = 2,
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] instruction,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  logic [XLEN-1:0] fetch_pc, inflight_pc;
  logic inflight, pop, empty, buf_full_unused;
  logic [CW-1:0] count;
  fetch_entry_t head;
  assign pop = instr_valid && instr_ready;
  assign imem_req = !rst && !redirect &&
                    (32'(count) + 32'(inflight) - 32'(pop) < 32'(BUF_DEPTH));
  assign imem_addr = fetch_pc;
  assign instr_valid = !empty;
  assign PC = empty ? '0 : head.pc;
  assign instruction = empty ? NOP_INSTR : head.instr;
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
    end
  end
  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight && !redirect),
    .pop   (pop),
    .flush (redirect),
    .din   ('{pc: inflight_pc, instr: imem_rdata}),
    .head  (head),
    .count (count),
    .full  (buf_full_unused),
    .empty (empty)
  );
endmodule
